// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are internal active-high, ordered {a,b,c,d,e,f,g}.
package display_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    localparam logic [1:0] DIG_U = 2'd0;
    localparam logic [1:0] DIG_T = 2'd1;
    localparam logic [1:0] DIG_H = 2'd2;

    // Scan order units -> tens -> hundreds -> units.
    function automatic logic [1:0] next_digit(input logic [1:0] d);
        return (d == DIG_H) ? DIG_U : d + 2'd1;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to internal active-high segment pattern.
// Non-decimal codes (10..15) decode to a dash.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// 3-digit multiplexed 7-segment driver: prescaler, digit scan, per-frame BCD latch,
// leading-zero blanking and pin polarity. Outputs are registered and change only on tick.
module bcd_display_mux
    import display_pkg::*;
#(
    parameter int DIV        = 1000,
    parameter int ACTIVE_LOW = 1,
    parameter int LZB        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] dec,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [31:0] LAST = 32'(DIV - 1);
    localparam logic [6:0] SEG_IDLE = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [2:0] AN_IDLE  = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

    logic [CW-1:0] cnt;
    logic [31:0]   cnt_wide;
    logic          tick;
    logic [1:0]    d;
    logic [1:0]    next_d;
    logic          frame_start;
    logic [9:0]    val;
    logic [9:0]    next_val;
    logic [1:0]    hun;
    logic [3:0]    ten;
    logic [3:0]    uni;
    logic [3:0]    dig_code;
    logic [6:0]    seg_raw;
    logic [6:0]    seg_int;
    logic [2:0]    an_int;
    logic          blank;
    logic [6:0]    seg_pin;
    logic [2:0]    an_pin;

    // Compare at 32 bits so DIV-1 is never truncated to the counter width.
    assign cnt_wide    = 32'(cnt);
    assign tick        = (cnt_wide == LAST);
    assign next_d      = next_digit(d);
    assign frame_start = tick && (d == DIG_H);
    assign next_val    = frame_start ? dec : val;

    assign hun = next_val[9:8];
    assign ten = next_val[7:4];
    assign uni = next_val[3:0];

    always_comb begin
        dig_code = uni;
        case (next_d)
            DIG_T:   dig_code = ten;
            DIG_H:   dig_code = {2'b00, hun};
            default: dig_code = uni;
        endcase
    end

    bcd_to_7seg u_dec (
        .code    (dig_code),
        .pattern (seg_raw)
    );

    // Dashes are non-zero, so a dashed hundreds keeps a zero tens digit visible.
    always_comb begin
        seg_int = seg_raw;
        blank   = 1'b0;
        case (next_d)
            DIG_H: begin
                if (hun == 2'd3) seg_int = SEG_DASH;
                blank = (LZB != 0) && (hun == 2'd0);
            end
            DIG_T: begin
                blank = (LZB != 0) && (hun == 2'd0) && (ten == 4'd0);
            end
            default: blank = 1'b0;
        endcase
        an_int = 3'b001 << next_d;
        if (blank) begin
            seg_int = SEG_OFF;
            an_int  = 3'b000;
        end
    end

    assign seg_pin = (ACTIVE_LOW != 0) ? ~seg_int : seg_int;
    assign an_pin  = (ACTIVE_LOW != 0) ? ~an_int  : an_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            d   <= DIG_H;
            val <= '0;
            seg <= SEG_IDLE;
            an  <= AN_IDLE;
        end else begin
            if (tick) begin
                cnt <= '0;
                d   <= next_d;
                val <= next_val;
                seg <= seg_pin;
                an  <= an_pin;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: table vectors, hand sequences and random dec/reset
// checked every cycle against a frame-level model of two parameter sets.
module tb_bcd_display_mux;

    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [9:0] dec;
    logic [6:0] seg1, seg2;
    logic [2:0] an1, an2;

    int nvec = 0;
    int nerr = 0;

    bcd_display_mux #(.DIV(DIV), .ACTIVE_LOW(1), .LZB(1)) dut (
        .clk(clk), .rst_n(rst_n), .dec(dec), .seg(seg1), .an(an1)
    );

    bcd_display_mux #(.DIV(DIV), .ACTIVE_LOW(0), .LZB(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .dec(dec), .seg(seg2), .an(an2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

    // Returns {an, seg} at the pins for one slot (0=units,1=tens,2=hundreds).
    function automatic logic [9:0] model(input logic [9:0] v, input int slot,
                                         input bit lzb, input bit al);
        int h, t, u, digit;
        bit dash, blank;
        logic [6:0] s;
        logic [2:0] a;
        h = int'(v[9:8]);
        t = int'(v[7:4]);
        u = int'(v[3:0]);
        digit = (slot == 0) ? u : (slot == 1) ? t : h;
        dash  = (slot == 2) ? (h == 3) : (digit > 9);
        blank = lzb && ((slot == 2 && h == 0) || (slot == 1 && h == 0 && t == 0));
        s = blank ? 7'b0 : dash ? 7'b0000001 : seg_tab[digit];
        a = blank ? 3'b000 : 3'(1 << slot);
        if (al) begin
            s = ~s;
            a = ~a;
        end
        return {a, s};
    endfunction

    int         k;
    logic [9:0] m_val;
    logic [9:0] exp1, exp2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        k     = 0;
        m_val = 10'd0;
        exp1  = {3'b111, 7'h7F};
        exp2  = 10'd0;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic cycle();
        int slot;
        @(posedge clk);
        if (rst_n) begin
            k++;
            if (k >= DIV && (k - DIV) % DIV == 0) begin
                slot = ((k - DIV) / DIV) % 3;
                if (slot == 0) m_val = dec;
                exp1 = model(m_val, slot, 1'b1, 1'b1);
                exp2 = model(m_val, slot, 1'b0, 1'b0);
            end
        end
        @(negedge clk);
        check("seg1", 32'(seg1), 32'(exp1[6:0]));
        check("an1", 32'(an1), 32'(exp1[9:7]));
        check("seg2", 32'(seg2), 32'(exp2[6:0]));
        check("an2", 32'(an2), 32'(exp2[9:7]));
        check("onehot1", 32'($countones(~an1) <= 1), 32'd1);
        check("onehot2", 32'($countones(an2) <= 1), 32'd1);
    endtask

    // Called on a falling edge; checks the outputs drop within the same cycle.
    task automatic do_reset(input int hold);
        dec   = 10'h0FF;
        rst_n = 1'b0;
        #1;
        check("rst_seg1", 32'(seg1), 32'h7F);
        check("rst_an1", 32'(an1), 32'h7);
        check("rst_seg2", 32'(seg2), 32'h0);
        check("rst_an2", 32'(an2), 32'h0);
        model_reset();
        repeat (hold) cycle();
        rst_n = 1'b1;
    endtask

    // Step until the slot at offset 'target' (0, DIV, 2*DIV) of a frame has just loaded.
    task automatic align(input int target);
        int i;
        for (i = 0; i < 3 * DIV + 1 && (k < DIV || (k - DIV) % (3 * DIV) != target); i++)
            cycle();
        check("align", 32'(k >= DIV && (k - DIV) % (3 * DIV) == target), 32'd1);
    endtask

    typedef struct {
        logic [9:0] dec;
        logic [6:0] su, st, sh;
        logic [2:0] au, at, ah;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{10'h255, 7'b0100100, 7'b0100100, 7'b0010010, 3'b110, 3'b101, 3'b011};
        vecs[1] = '{10'h007, 7'b0001111, 7'h7F,      7'h7F,      3'b110, 3'b111, 3'b111};
        vecs[2] = '{10'h000, 7'b0000001, 7'h7F,      7'h7F,      3'b110, 3'b111, 3'b111};
        vecs[3] = '{10'h0A3, 7'b0000110, 7'b1111110, 7'h7F,      3'b110, 3'b101, 3'b111};
        vecs[4] = '{10'h128, 7'b0000000, 7'b0010010, 7'b1001111, 3'b110, 3'b101, 3'b011};
        vecs[5] = '{10'h300, 7'b0000001, 7'b0000001, 7'b1111110, 3'b110, 3'b101, 3'b011};
        vecs[6] = '{10'h0F9, 7'b0000100, 7'b1111110, 7'h7F,      3'b110, 3'b101, 3'b111};

        rst_n = 1'b0;
        dec   = 10'h0FF;
        model_reset();
        @(negedge clk);
        repeat (2) cycle();
        rst_n = 1'b1;
        dec   = 10'h255;
        repeat (DIV - 1) cycle();
        check("hold_seg1", 32'(seg1), 32'h7F);
        check("hold_an1", 32'(an1), 32'h7);
        cycle();
        check("first_an1", 32'(an1), 32'b110);
        check("first_seg1", 32'(seg1), 32'b0100100);

        for (int i = 0; i < 7; i++) begin
            dec = vecs[i].dec;
            repeat (6 * DIV) cycle();
            align(0);
            check("tab_seg_u", 32'(seg1), 32'(vecs[i].su));
            check("tab_an_u", 32'(an1), 32'(vecs[i].au));
            repeat (DIV) cycle();
            check("tab_seg_t", 32'(seg1), 32'(vecs[i].st));
            check("tab_an_t", 32'(an1), 32'(vecs[i].at));
            repeat (DIV) cycle();
            check("tab_seg_h", 32'(seg1), 32'(vecs[i].sh));
            check("tab_an_h", 32'(an1), 32'(vecs[i].ah));
        end

        // Change dec while tens is displayed: the frame in progress keeps 255.
        dec = 10'h255;
        repeat (6 * DIV) cycle();
        align(DIV);
        dec = 10'h128;
        repeat (DIV) cycle();
        check("mid_seg_h", 32'(seg1), 32'b0010010);
        check("mid_an_h", 32'(an1), 32'b011);
        repeat (DIV) cycle();
        check("mid_seg_u", 32'(seg1), 32'b0000000);
        check("mid_an_u", 32'(an1), 32'b110);
        repeat (DIV) cycle();
        check("mid_seg_t", 32'(seg1), 32'b0010010);
        repeat (DIV) cycle();
        check("mid_seg_h2", 32'(seg1), 32'b1001111);

        // No blanking, active-high instance: dec=7 shows "007".
        dec = 10'h007;
        repeat (6 * DIV) cycle();
        align(DIV);
        check("p_seg_t", 32'(seg2), 32'b1111110);
        check("p_an_t", 32'(an2), 32'b010);
        repeat (DIV) cycle();
        check("p_seg_h", 32'(seg2), 32'b1111110);
        check("p_an_h", 32'(an2), 32'b100);
        repeat (DIV) cycle();
        check("p_seg_u", 32'(seg2), 32'b1110000);
        check("p_an_u", 32'(an2), 32'b001);

        // Mid-frame reset then release, outputs must hold for DIV-1 cycles.
        repeat (DIV + 1) cycle();
        do_reset(3);
        repeat (DIV - 1) cycle();
        check("rel_seg1", 32'(seg1), 32'h7F);

        for (int i = 0; i < 60; i++) begin
            dec = 10'($urandom_range(0, 1023));
            repeat ($urandom_range(1, 6 * DIV)) cycle();
            if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
        end
        repeat (6 * DIV) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
